// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: requester indices
// and the architectural register numbers it treats specially.
package regfile_pkg;

   localparam int NUM_WB_REQ = 3;

   typedef enum logic [1:0] {
      REQ_ALU = 2'd0,
      REQ_LD  = 2'd1,
      REQ_LNK = 2'd2
   } wb_req_e;

   localparam logic [4:0] LINK_REG = 5'd31;
   localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory paths and the regfile write-port arbiter.
// master = requester/consumer side, slave = the arbiter.
interface regfile_wb_arbiter_if #(
   parameter int n  = 32,
   parameter int r  = 5,
   parameter int cw = 16
);
   logic          hold;
   logic          alu_valid, alu_ready;
   logic [r-1:0]  alu_addr;
   logic [n-1:0]  alu_data;
   logic          ld_valid, ld_ready;
   logic [r-1:0]  ld_addr;
   logic [n-1:0]  ld_data;
   logic          lnk_valid, lnk_ready;
   logic [n-1:0]  lnk_pcplus4;
   logic          rf_we;
   logic [r-1:0]  rf_wa;
   logic [n-1:0]  rf_wd;
   logic [r-1:0]  chk_addr;
   logic          chk_pending;
   logic [cw-1:0] wr_count;

   modport master (
      output hold, alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
             lnk_valid, lnk_pcplus4, chk_addr,
      input  alu_ready, ld_ready, lnk_ready, rf_we, rf_wa, rf_wd, chk_pending, wr_count
   );

   modport slave (
      input  hold, alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
             lnk_valid, lnk_pcplus4, chk_addr,
      output alu_ready, ld_ready, lnk_ready, rf_we, rf_wa, rf_wd, chk_pending, wr_count
   );
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: searches last+1, last+2, ... last (mod N) and grants the
// first active request; the pointer moves only when the grant is accepted.
module rr_arbiter #(
   parameter int  N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [N-1:0]  req,
   input  logic          en,
   input  logic          accept,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] last
);

   logic [IW-1:0] win;

   always_comb begin
      int   k;
      logic found;
      gnt   = '0;
      win   = last;
      found = 1'b0;
      k     = 0;
      for (int i = 1; i <= N; i++) begin
         k = (int'(last) + i) % N;
         if (!found && req[k]) begin
            found  = 1'b1;
            win    = IW'(k);
            gnt[k] = en;
         end
      end
   end

   // Reset to the highest index so requester 0 wins the first search.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    last <= IW'(N - 1);
      else if (accept) last <= win;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port among ALU, load and link writeback sources with a
// registered output stage, a pending-write lookup and a saturating write counter.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int n  = 32,
   parameter int r  = 5,
   parameter int cw = 16
) (
   input logic                 clk,
   input logic                 reset_n,
   regfile_wb_arbiter_if.slave wb
);

   localparam int LW = $clog2(NUM_WB_REQ);

   logic [NUM_WB_REQ-1:0]        req, gnt, xfer;
   logic [NUM_WB_REQ-1:0][r-1:0] req_addr;
   logic [NUM_WB_REQ-1:0][n-1:0] req_data;
   logic                         accept;
   logic [r-1:0]                 sel_addr;
   logic [n-1:0]                 sel_data;
   logic [LW-1:0]                unused_rr_last;
   logic                         rf_we_q;
   logic [r-1:0]                 rf_wa_q;
   logic [n-1:0]                 rf_wd_q;
   logic [cw-1:0]                cnt_q;

   assign req      = {wb.lnk_valid,     wb.ld_valid, wb.alu_valid};
   assign req_addr = {r'(LINK_REG),     wb.ld_addr,  wb.alu_addr};
   assign req_data = {wb.lnk_pcplus4,   wb.ld_data,  wb.alu_data};

   // Grants are masked while reset is low so no requester sees a false acceptance.
   rr_arbiter #(.N(NUM_WB_REQ)) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .en      (~wb.hold & reset_n),
      .accept  (accept),
      .gnt     (gnt),
      .last    (unused_rr_last)
   );

   assign xfer   = gnt & req;
   assign accept = |xfer;

   assign wb.alu_ready = gnt[REQ_ALU];
   assign wb.ld_ready  = gnt[REQ_LD];
   assign wb.lnk_ready = gnt[REQ_LNK];

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_WB_REQ; i++) begin
         if (xfer[i]) begin
            sel_addr = sel_addr | req_addr[i];
            sel_data = sel_data | req_data[i];
         end
      end
   end

   // Writes to r0 still complete the handshake but never reach the regfile.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_we_q <= 1'b0;
         rf_wa_q <= '0;
         rf_wd_q <= '0;
      end else if (accept) begin
         rf_we_q <= (sel_addr != r'(ZERO_REG));
         rf_wa_q <= sel_addr;
         rf_wd_q <= sel_data;
      end else begin
         rf_we_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                   cnt_q <= '0;
      else if (rf_we_q && ~&cnt_q)    cnt_q <= cnt_q + 1'b1;
   end

   assign wb.rf_we       = rf_we_q;
   assign wb.rf_wa       = rf_wa_q;
   assign wb.rf_wd       = rf_wd_q;
   assign wb.wr_count    = cnt_q;
   assign wb.chk_pending = rf_we_q && (rf_wa_q == wb.chk_addr) && (wb.chk_addr != r'(ZERO_REG));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, rotation, r0 writes,
// hold, pending lookup, mid-stream reset and counter saturation (cw=4 instance).
module tb_regfile_wb_arbiter;

   logic clk;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   regfile_wb_arbiter_if #(.n(32), .r(5), .cw(16)) wb  ();
   regfile_wb_arbiter_if #(.n(32), .r(5), .cw(4))  wb4 ();

   regfile_wb_arbiter #(.n(32), .r(5), .cw(16)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wb      (wb)
   );

   regfile_wb_arbiter #(.n(32), .r(5), .cw(4)) u_dut4 (
      .clk     (clk),
      .reset_n (reset_n),
      .wb      (wb4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      wb.hold = 0; wb.alu_valid = 0; wb.ld_valid = 0; wb.lnk_valid = 0;
      wb4.hold = 0; wb4.alu_valid = 0; wb4.ld_valid = 0; wb4.lnk_valid = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      reset_n = 0;
      #1 reset_n = 1;
   endtask

   task automatic test_reset();
      reset_n = 0;
      idle();
      wb.alu_addr = 5'd0; wb.alu_data = '0; wb.ld_addr = 5'd0; wb.ld_data = '0;
      wb.lnk_pcplus4 = '0; wb.chk_addr = 5'd0;
      wb4.alu_addr = 5'd1; wb4.alu_data = 32'h1; wb4.ld_addr = 5'd0; wb4.ld_data = '0;
      wb4.lnk_pcplus4 = '0; wb4.chk_addr = 5'd0;
      wb.alu_valid = 1;
      #2;
      total++; if (wb.alu_ready !== 1'b0) begin bad++; $display("FAIL reset_alu_ready got=%b exp=0", wb.alu_ready); end
      total++; if (wb.rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", wb.rf_we); end
      total++; if (wb.rf_wa !== 5'd0) begin bad++; $display("FAIL reset_rf_wa got=%0d exp=0", wb.rf_wa); end
      total++; if (wb.rf_wd !== 32'd0) begin bad++; $display("FAIL reset_rf_wd got=%h exp=0", wb.rf_wd); end
      total++; if (wb.wr_count !== 16'd0) begin bad++; $display("FAIL reset_wr_count got=%0d exp=0", wb.wr_count); end
      @(negedge clk);
      wb.alu_valid = 0;
      reset_n = 1;
   endtask

   task automatic test_alu_single();
      @(negedge clk);
      wb.alu_valid = 1; wb.alu_addr = 5'd5; wb.alu_data = 32'hDEADBEEF;
      #1;
      total++; if (wb.alu_ready !== 1'b1) begin bad++; $display("FAIL alu_ready got=%b exp=1", wb.alu_ready); end
      total++; if (wb.ld_ready !== 1'b0) begin bad++; $display("FAIL alu_ld_ready got=%b exp=0", wb.ld_ready); end
      @(posedge clk); #1;
      total++; if (wb.rf_we !== 1'b1) begin bad++; $display("FAIL alu_rf_we got=%b exp=1", wb.rf_we); end
      total++; if (wb.rf_wa !== 5'd5) begin bad++; $display("FAIL alu_rf_wa got=%0d exp=5", wb.rf_wa); end
      total++; if (wb.rf_wd !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_rf_wd got=%h exp=deadbeef", wb.rf_wd); end
      @(negedge clk);
      wb.alu_valid = 0;
      @(posedge clk); #1;
      total++; if (wb.wr_count !== 16'd1) begin bad++; $display("FAIL alu_wr_count got=%0d exp=1", wb.wr_count); end
      total++; if (wb.rf_we !== 1'b0) begin bad++; $display("FAIL alu_rf_we_drop got=%b exp=0", wb.rf_we); end
   endtask

   task automatic test_round_robin();
      logic [2:0]  rdy;
      logic [2:0]  exp_rdy;
      logic [4:0]  exp_wa;
      logic [31:0] exp_wd;
      do_reset();
      @(negedge clk);
      wb.alu_valid = 1; wb.alu_addr = 5'd3; wb.alu_data = 32'hA3;
      wb.ld_valid  = 1; wb.ld_addr  = 5'd4; wb.ld_data  = 32'hB4;
      wb.lnk_valid = 1; wb.lnk_pcplus4 = 32'h40;
      for (int i = 0; i < 6; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         case (i % 3)
            0:       begin exp_rdy = 3'b001; exp_wa = 5'd3;  exp_wd = 32'hA3; end
            1:       begin exp_rdy = 3'b010; exp_wa = 5'd4;  exp_wd = 32'hB4; end
            default: begin exp_rdy = 3'b100; exp_wa = 5'd31; exp_wd = 32'h40; end
         endcase
         rdy = {wb.lnk_ready, wb.ld_ready, wb.alu_ready};
         total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, rdy, exp_rdy); end
         @(posedge clk); #1;
         total++; if (wb.rf_we !== 1'b1 || wb.rf_wa !== exp_wa || wb.rf_wd !== exp_wd) begin
            bad++; $display("FAIL rr_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, wb.rf_we, wb.rf_wa, wb.rf_wd, exp_wa, exp_wd);
         end
      end
      @(negedge clk);
      idle();
      @(posedge clk); #1;
      total++; if (wb.wr_count !== 16'd6) begin bad++; $display("FAIL rr_wr_count got=%0d exp=6", wb.wr_count); end
   endtask

   task automatic test_zero_addr();
      @(negedge clk);
      wb.ld_valid = 1; wb.ld_addr = 5'd0; wb.ld_data = 32'h1234;
      #1;
      total++; if (wb.ld_ready !== 1'b1) begin bad++; $display("FAIL zero_ld_ready got=%b exp=1", wb.ld_ready); end
      @(posedge clk); #1;
      total++; if (wb.rf_we !== 1'b0) begin bad++; $display("FAIL zero_rf_we got=%b exp=0", wb.rf_we); end
      total++; if (wb.rf_wd !== 32'h1234) begin bad++; $display("FAIL zero_rf_wd got=%h exp=1234", wb.rf_wd); end
      @(negedge clk);
      wb.ld_valid = 0;
      wb.alu_valid = 1; wb.alu_addr = 5'd9; wb.lnk_valid = 1; wb.lnk_pcplus4 = 32'h80;
      #1;
      total++; if (wb.wr_count !== 16'd6) begin bad++; $display("FAIL zero_wr_count got=%0d exp=6", wb.wr_count); end
      // last advanced to LD on the r0 transfer, so LNK is searched before ALU
      total++; if ({wb.lnk_ready, wb.alu_ready} !== 2'b10) begin
         bad++; $display("FAIL zero_last_adv got=%b exp=10", {wb.lnk_ready, wb.alu_ready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_hold();
      @(negedge clk);
      idle();
      wb.hold = 1; wb.alu_valid = 1; wb.alu_addr = 5'd7; wb.alu_data = 32'h77; wb.ld_valid = 1;
      #1;
      total++; if (wb.rf_we !== 1'b1 || wb.rf_wa !== 5'd31) begin
         bad++; $display("FAIL hold_inflight got=%b/%0d exp=1/31", wb.rf_we, wb.rf_wa);
      end
      for (int i = 0; i < 3; i++) begin
         if (i != 0) begin @(negedge clk); #1; end
         total++; if (wb.alu_ready !== 1'b0 || wb.ld_ready !== 1'b0) begin
            bad++; $display("FAIL hold_ready[%0d] got=%b%b exp=00", i, wb.alu_ready, wb.ld_ready);
         end
         @(posedge clk); #1;
         total++; if (wb.rf_we !== 1'b0) begin bad++; $display("FAIL hold_rf_we[%0d] got=%b exp=0", i, wb.rf_we); end
      end
      @(negedge clk);
      wb.hold = 0; wb.ld_valid = 0;
      wb.ld_valid = 1;
      #1;
      total++; if ({wb.ld_ready, wb.alu_ready} !== 2'b01) begin
         bad++; $display("FAIL hold_release got=%b exp=01", {wb.ld_ready, wb.alu_ready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_chk_pending();
      total++; if (wb.rf_we !== 1'b1 || wb.rf_wa !== 5'd7) begin
         bad++; $display("FAIL chk_stage got=%b/%0d exp=1/7", wb.rf_we, wb.rf_wa);
      end
      wb.chk_addr = 5'd7; #0.5;
      total++; if (wb.chk_pending !== 1'b1) begin bad++; $display("FAIL chk_hit got=%b exp=1", wb.chk_pending); end
      wb.chk_addr = 5'd8; #0.5;
      total++; if (wb.chk_pending !== 1'b0) begin bad++; $display("FAIL chk_miss got=%b exp=0", wb.chk_pending); end
      wb.chk_addr = 5'd0; #0.5;
      total++; if (wb.chk_pending !== 1'b0) begin bad++; $display("FAIL chk_zero got=%b exp=0", wb.chk_pending); end
   endtask

   task automatic test_reset_midstream();
      total++; if (wb.wr_count !== 16'd7) begin bad++; $display("FAIL mid_pre_count got=%0d exp=7", wb.wr_count); end
      reset_n = 0;
      #0.5;
      total++; if (wb.rf_we !== 1'b0) begin bad++; $display("FAIL mid_rf_we got=%b exp=0", wb.rf_we); end
      total++; if (wb.wr_count !== 16'd0) begin bad++; $display("FAIL mid_wr_count got=%0d exp=0", wb.wr_count); end
      total++; if (wb.alu_ready !== 1'b0) begin bad++; $display("FAIL mid_alu_ready got=%b exp=0", wb.alu_ready); end
      @(negedge clk);
      idle();
      reset_n = 1;
   endtask

   task automatic test_saturate();
      @(negedge clk);
      wb4.alu_valid = 1; wb4.alu_addr = 5'd1; wb4.alu_data = 32'h1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (i == 15) begin
            total++; if (wb4.wr_count !== 4'd14) begin bad++; $display("FAIL sat_mid got=%0d exp=14", wb4.wr_count); end
         end
      end
      @(negedge clk);
      idle();
      repeat (2) @(posedge clk);
      #1;
      total++; if (wb4.wr_count !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", wb4.wr_count); end
   endtask

   initial begin
      test_reset();
      test_alu_single();
      test_round_robin();
      test_zero_addr();
      test_hold();
      test_chk_pending();
      test_reset_midstream();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port (we3/wa3/wd3 on `regfile`) among three writeback sources: ALU result, load data and jal link address. Each source uses a valid/ready handshake. The block arbitrates round-robin and drives the write port from a registered output stage. It also exposes a pending-write lookup for hazard logic and a saturating write counter. It sits between the execute/memory writeback paths and `regfile`.

## Interface
- `n`, 32, register data width
- `r`, 5, register address width
- `cw`, 16, width of write counter

- `clk`  in  1  clock, rising edge active
- `reset_n`  in  1  asynchronous, active-low reset
- `hold`  in  1  freeze arbitration; no grants while high
- `alu_valid` / `alu_ready`  in / out  1 / 1  ALU writeback handshake
- `alu_addr`, `alu_data`  in  r, n  ALU destination and value
- `ld_valid` / `ld_ready`  in / out  1 / 1  load writeback handshake
- `ld_addr`, `ld_data`  in  r, n  load destination and value
- `lnk_valid` / `lnk_ready`  in / out  1 / 1  link writeback handshake
- `lnk_pcplus4`  in  n  link value; destination fixed to register 31
- `rf_we`  out  1  to regfile we3
- `rf_wa`  out  r  to regfile wa3
- `rf_wd`  out  n  to regfile wd3
- `chk_addr`  in  r  register to query
- `chk_pending`  out  1  `chk_addr` has a write in the output stage
- `wr_count`  out  cw  saturating count of committed nonzero-register writes

## Operation
- Requesters have fixed indices: ALU=0, LD=1, LNK=2.
- Round-robin pointer `last` holds the last granted index. Search order is `last`+1, `last`+2, `last`, mod 3. The first requester in that order with valid high is granted.
- `x_ready` = grant_x & ~`hold`, combinational. At most one ready is high per cycle.
- A transfer occurs when `x_valid` & `x_ready` are both high. On a transfer, `last` is set to x.
- On a transfer to address 0, the handshake completes but `rf_we` stays low next cycle. `wr_count` does not increment, and `last` still advances.
- LNK always writes address 31.
- Output stage, each cycle:
  - On a transfer: `rf_we` = (addr≠0), `rf_wa` = addr, `rf_wd` = data.
  - Otherwise: `rf_we` = 0, and `rf_wa`/`rf_wd` hold their values.
- `chk_pending` = `rf_we` & (`rf_wa` == `chk_addr`) & (`chk_addr`≠0).
- `wr_count` increments on each cycle with `rf_we` high and saturates at 2^cw−1.
- Requesters must hold valid, addr and data stable until accepted. The block does not buffer unaccepted requests.

## Timing
- Reset values (asynchronous on `reset_n` low):
  - `rf_we`=0, `rf_wa`=0, `rf_wd`=0, `wr_count`=0.
  - `last`=2, so ALU has first priority.
  - All readies are low while reset is asserted.
- Latency: a transfer in cycle t appears on `rf_*` in cycle t+1. `regfile` commits it at the edge ending t+1.
- Throughput: one write per cycle. With all three valid continuously, grants rotate 0,1,2,0…
- `hold` high: no readies, `rf_we`=0 in the following cycle, and `last` is frozen. A write already in the output stage still completes.
- Same-address requests in the same cycle are serialized in round-robin order. The later grant lands one cycle later and wins.
- Reset asserted mid-stream drops any output-stage write: `rf_we` goes low immediately. Requesters see no acceptance.
- `chk_pending` is combinational from `chk_addr` and registered state. There is no path from valid to `chk_pending`.

## Structure
- Package `regfile_pkg`:
  - requester index typedef (`REQ_ALU`, `REQ_LD`, `REQ_LNK`)
  - `NUM_WB_REQ`=3
  - `LINK_REG`=5'd31
  - `ZERO_REG`=5'd0
- Sub-module `rr_arbiter`:
  - parameterized on requester count
  - inputs: request vector, enable (~`hold`), accept
  - outputs: one-hot grant and `last` state
- Top level contains the data/address mux, the output register, `chk_pending` and the counter.

## Test plan
- Reset, then ALU only: addr 5, data 0xDEADBEEF → `alu_ready`=1 same cycle; next cycle `rf_we`=1, `rf_wa`=5, `rf_wd`=0xDEADBEEF; `wr_count`=1 after that edge.
- All three valid for 6 cycles (ALU→3, LD→4, LNK pc+4=0x40) → grant order ALU,LD,LNK,ALU,LD,LNK; LNK writes `rf_wa`=31, `rf_wd`=0x40.
- LD to addr 0 with data 0x1234 → `ld_ready`=1, next cycle `rf_we`=0, `wr_count` unchanged.
- `hold`=1 for 3 cycles with ALU valid → `alu_ready`=0 and `rf_we`=0 throughout; first grant after release goes to the requester following `last`.
- Output stage writing addr 7: `chk_addr`=7 → `chk_pending`=1; `chk_addr`=8 → 0; `chk_addr`=0 → 0.
- Drop `reset_n` while `rf_we`=1 → `rf_we`=0 and `wr_count`=0 immediately, without waiting for a clock edge. Separately, with `cw`=4 and 20 writes, `wr_count` holds at 15.
